// File: rtl/eq_search_ctrl.sv
// ---------------------------------------------------------------------------
// eq_search_ctrl
//
// Sequencer that time-shares one external 16-bit equality comparator to
// search an NENTRIES-deep, combinational-read table for a 16-bit key. It
// walks the table one entry per cycle and reports the lowest matching index,
// or a miss.
//
// Ports
//   clk       in   1   clock
//   rst       in   1   asynchronous active-high reset
//   req_val   in   1   request valid
//   req_rdy   out  1   request ready (high only while idle)
//   req_key   in   16  search key, captured when the request is accepted
//   tbl_addr  out  AW  table read address
//   tbl_data  in   16  table read data, combinational from tbl_addr
//   cmp_in0   out  16  comparator operand 0 (the captured key)
//   cmp_in1   out  16  comparator operand 1 (the current table word)
//   cmp_eq    in   1   comparator result
//   resp_val  out  1   response valid
//   resp_rdy  in   1   response ready
//   resp_hit  out  1   1 = a match was found
//   resp_idx  out  AW  matching index (0 on a miss)
// ---------------------------------------------------------------------------
module eq_search_ctrl #(
  parameter  int NENTRIES = 8,
  localparam int AW       = $clog2(NENTRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_val,
  output logic          req_rdy,
  input  logic [15:0]   req_key,
  output logic [AW-1:0] tbl_addr,
  input  logic [15:0]   tbl_data,
  output logic [15:0]   cmp_in0,
  output logic [15:0]   cmp_in1,
  input  logic          cmp_eq,
  output logic          resp_val,
  input  logic          resp_rdy,
  output logic          resp_hit,
  output logic [AW-1:0] resp_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [15:0]   key_reg;
  logic [AW-1:0] idx;
  logic          hit_reg;
  logic          last;

  assign last = (idx == AW'(NENTRIES - 1));

  // Sequencer. The SCAN step is written with bitwise OR and ternaries rather
  // than an if/else on cmp_eq, so an unknown comparator result shows up as an
  // unknown state/response instead of silently being taken as a miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      key_reg <= '0;
      idx     <= '0;
      hit_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_val) begin
            key_reg <= req_key;
            idx     <= '0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          state   <= (cmp_eq | last) ? RESP : SCAN;
          hit_reg <= cmp_eq;
          idx     <= cmp_eq ? idx : (last ? '0 : idx + 1'b1);
        end
        RESP: begin
          if (resp_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Everything the requester and responder see is decoded from registers
  // only, so neither handshake has a combinational path through this block.
  assign req_rdy  = (state == IDLE);
  assign resp_val = (state == RESP);
  assign resp_hit = (state == RESP) & hit_reg;
  assign resp_idx = (state == RESP) ? idx : '0;

  assign tbl_addr = idx;
  assign cmp_in0  = key_reg;
  assign cmp_in1  = tbl_data;

endmodule

// File: tb/tb_eq_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_eq_search_ctrl
//
// Bench for eq_search_ctrl with NENTRIES=8. The bench owns the table memory
// and the equality comparator that the controller drives.
// ---------------------------------------------------------------------------
module tb_eq_search_ctrl;

  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk;
  logic          rst;
  logic          req_val;
  logic          req_rdy;
  logic [15:0]   req_key;
  logic [AW-1:0] tbl_addr;
  logic [15:0]   tbl_data;
  logic [15:0]   cmp_in0;
  logic [15:0]   cmp_in1;
  logic          cmp_eq;
  logic          resp_val;
  logic          resp_rdy;
  logic          resp_hit;
  logic [AW-1:0] resp_idx;

  logic [15:0] tbl [N];

  int total;
  int bad;

  eq_search_ctrl #(.NENTRIES(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_key  (req_key),
    .tbl_addr (tbl_addr),
    .tbl_data (tbl_data),
    .cmp_in0  (cmp_in0),
    .cmp_in1  (cmp_in1),
    .cmp_eq   (cmp_eq),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_hit (resp_hit),
    .resp_idx (resp_idx)
  );

  // Combinational table read and the shared comparator.
  assign tbl_data = tbl[tbl_addr];
  assign cmp_eq   = (cmp_in0 == cmp_in1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] key;
    logic        exp_hit;
    int          exp_idx;
    int          exp_lat;
  } vec_t;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Lowest matching index, computed straight from the table contents.
  task automatic model_search(input logic [15:0] key, output logic hit, output int idx, output int lat);
    hit = 1'b0;
    idx = 0;
    lat = N;
    for (int i = 0; i < N; i++) begin
      if (!hit && tbl[i] == key) begin
        hit = 1'b1;
        idx = i;
        lat = i + 1;
      end
    end
  endtask

  // Issue one request and wait for the response. Called just after a rising
  // edge; returns #1 after the edge on which resp_val rose. lat counts edges
  // after the accept edge. addr_ok tracks the address walk and the operands.
  task automatic apply_stimulus(input logic [15:0] key, output logic hit, output int idx,
                                output int lat, output logic addr_ok);
    int n;
    n = 0;
    while (!req_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_rdy) check_output("req_rdy_wait", {31'd0, req_rdy}, 32'd1);
    req_val = 1'b1;
    req_key = key;
    @(posedge clk); #1;
    req_val = 1'b0;
    lat = 0;
    addr_ok = 1'b1;
    while (!resp_val && lat < 40) begin
      if (int'(tbl_addr) != lat) addr_ok = 1'b0;
      if (cmp_in0 !== key) addr_ok = 1'b0;
      if (cmp_in1 !== tbl[tbl_addr]) addr_ok = 1'b0;
      if (req_rdy !== 1'b0) addr_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    hit = resp_hit;
    idx = int'(resp_idx);
  endtask

  task automatic finish_resp(input string name);
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    resp_rdy = 1'b0;
    check_output({name, "_rdy_after"}, {31'd0, req_rdy}, 32'd1);
    check_output({name, "_val_after"}, {31'd0, resp_val}, 32'd0);
  endtask

  initial begin
    vec_t        vecs [6];
    logic        hit, mhit, aok;
    int          idx, lat, midx, mlat;
    logic [15:0] key;

    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    req_val  = 1'b0;
    req_key  = '0;
    resp_rdy = 1'b0;
    tbl[0] = 16'h0000; tbl[1] = 16'h1234; tbl[2] = 16'hA0A0; tbl[3] = 16'hFFFF;
    tbl[4] = 16'h1234; tbl[5] = 16'h4343; tbl[6] = 16'h2468; tbl[7] = 16'hBEEF;

    vecs[0] = '{16'h0000, 1'b1, 0, 1};
    vecs[1] = '{16'h1234, 1'b1, 1, 2};
    vecs[2] = '{16'hBEEF, 1'b1, 7, 8};
    vecs[3] = '{16'h5555, 1'b0, 0, 8};
    vecs[4] = '{16'hA0A0, 1'b1, 2, 3};
    vecs[5] = '{16'h4343, 1'b1, 5, 6};

    // Reset state
    #2;
    check_output("rst_req_rdy",  {31'd0, req_rdy},  32'd1);
    check_output("rst_resp_val", {31'd0, resp_val}, 32'd0);
    check_output("rst_resp_hit", {31'd0, resp_hit}, 32'd0);
    check_output("rst_resp_idx", {29'd0, resp_idx}, 32'd0);
    check_output("rst_tbl_addr", {29'd0, tbl_addr}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed table vectors
    for (int v = 0; v < 6; v++) begin
      apply_stimulus(vecs[v].key, hit, idx, lat, aok);
      $display("[TB] vector %0d key=%h hit=%0d idx=%0d lat=%0d", v, vecs[v].key, hit, idx, lat);
      check_output($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
      check_output($sformatf("vec%0d_hit", v), {31'd0, hit}, {31'd0, vecs[v].exp_hit});
      check_output($sformatf("vec%0d_idx", v), idx, vecs[v].exp_idx);
      check_output($sformatf("vec%0d_addr", v), {31'd0, aok}, 32'd1);
      finish_resp($sformatf("vec%0d", v));
    end

    // Response held off for 3 cycles with a competing request pending
    apply_stimulus(16'hFFFF, hit, idx, lat, aok);
    check_output("hold_lat", lat, 4);
    req_val = 1'b1;
    req_key = 16'h0000;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_output($sformatf("hold%0d_val", c), {31'd0, resp_val}, 32'd1);
      check_output($sformatf("hold%0d_hit", c), {31'd0, resp_hit}, 32'd1);
      check_output($sformatf("hold%0d_idx", c), {29'd0, resp_idx}, 32'd3);
      check_output($sformatf("hold%0d_rdy", c), {31'd0, req_rdy},  32'd0);
    end
    req_val = 1'b0;
    finish_resp("hold");
    apply_stimulus(16'h0000, hit, idx, lat, aok);
    check_output("after_hold_idx", idx, 0);
    check_output("after_hold_hit", {31'd0, hit}, 32'd1);
    finish_resp("after_hold");

    // Reset pulse in the middle of a scan
    req_val = 1'b1;
    req_key = 16'hBEEF;
    @(posedge clk); #1;
    req_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("mid_addr_before", {29'd0, tbl_addr}, 32'd3);
    #2 rst = 1'b1;
    #1;
    check_output("mid_rst_val",  {31'd0, resp_val}, 32'd0);
    check_output("mid_rst_rdy",  {31'd0, req_rdy},  32'd1);
    check_output("mid_rst_addr", {29'd0, tbl_addr}, 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_output("mid_rst_idle", {31'd0, req_rdy}, 32'd1);
    apply_stimulus(16'hA0A0, hit, idx, lat, aok);
    check_output("post_rst_idx", idx, 2);
    check_output("post_rst_lat", lat, 3);
    finish_resp("post_rst");

    // Randomized tables (small value alphabet for duplicates) and keys
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) tbl[i] = 16'h7000 + 16'($urandom_range(0, 5));
      key = 16'h7000 + 16'($urandom_range(0, 6));
      model_search(key, mhit, midx, mlat);
      apply_stimulus(key, hit, idx, lat, aok);
      check_output($sformatf("rnd%0d_hit", r), {31'd0, hit}, {31'd0, mhit});
      check_output($sformatf("rnd%0d_idx", r), idx, midx);
      check_output($sformatf("rnd%0d_lat", r), lat, mlat);
      check_output($sformatf("rnd%0d_addr", r), {31'd0, aok}, 32'd1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      check_output($sformatf("rnd%0d_stable", r), {28'd0, resp_val, resp_hit, resp_idx},
                   {28'd0, 1'b1, mhit, 3'(midx)});
      finish_resp($sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time limit so a stuck design still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
